// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the memory arbiter.
//   state_e   - arbiter FSM encoding (IDLE/RUN/ACK, 2 bits)
//   PORT_*    - grant identifiers for the fetch and data ports
//   BE_N_*    - active-low byte-enable constants
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_ACK  = 2'd2
  } state_e;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_DM = 1'b1;

  localparam logic [3:0] BE_N_NONE = 4'b1111;
  localparam logic [3:0] BE_N_ALL  = 4'b0000;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (fetch / data) round-robin arbiter in front of the
// SRAM controller. One access at a time; strobes are active-low and always
// return high for at least one cycle between accesses. A watchdog ends any
// access the controller never completes and flags it on err_o.
//
// Ports:
//   clk_i, rst_n_i            clock, async active-low reset
//   if_req_i/if_addr_i        fetch read request (held until if_ack_o)
//   if_ack_o/if_rdata_o       fetch completion pulse / held read data
//   dm_req_i/dm_we_i/dm_be_n_i/dm_addr_i/dm_wdata_i   data request fields
//   dm_ack_o/dm_rdata_o       data completion pulse / held load data
//   err_o                     pulses with an ack that ended by timeout
//   ctl_re_n_o/ctl_we_n_o     controller strobes (active-low)
//   ctl_be_n_o/ctl_addr_o/ctl_wdata_o   controller access fields
//   ctl_rdata_i/ctl_ok_i      controller read data / completion pulse
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | strobes high, waiting for a request; grants on the next edge
// RUN   | one strobe low, waiting for ctl_ok_i or watchdog expiry
// ACK   | ack (and err) visible for one cycle; no grant in this state
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_ack_o,
  output logic [31:0] if_rdata_o,
  input  logic        dm_req_i,
  input  logic        dm_we_i,
  input  logic [3:0]  dm_be_n_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_wdata_i,
  output logic        dm_ack_o,
  output logic [31:0] dm_rdata_o,
  output logic        err_o,
  output logic        ctl_re_n_o,
  output logic        ctl_we_n_o,
  output logic [3:0]  ctl_be_n_o,
  output logic [31:0] ctl_addr_o,
  output logic [31:0] ctl_wdata_o,
  input  logic [31:0] ctl_rdata_i,
  input  logic        ctl_ok_i
);

  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

  state_e      state_q, state_d;
  logic        grant_q, grant_d;
  logic        last_dm_q, last_dm_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        re_n_q, re_n_d;
  logic        we_n_q, we_n_d;
  logic [3:0]  be_n_q, be_n_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] dm_rdata_q, dm_rdata_d;
  logic        if_ack_q, if_ack_d;
  logic        dm_ack_q, dm_ack_d;
  logic        err_q, err_d;

  logic        pick_dm;
  logic        finish;
  logic [7:0]  cnt_inc;

  assign cnt_inc = cnt_q + 8'd1;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_IDLE;
      grant_q    <= PORT_IF;
      last_dm_q  <= 1'b0;
      cnt_q      <= '0;
      re_n_q     <= 1'b1;
      we_n_q     <= 1'b1;
      be_n_q     <= BE_N_NONE;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      if_ack_q   <= 1'b0;
      dm_ack_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_dm_q  <= last_dm_d;
      cnt_q      <= cnt_d;
      re_n_q     <= re_n_d;
      we_n_q     <= we_n_d;
      be_n_q     <= be_n_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
      if_ack_q   <= if_ack_d;
      dm_ack_q   <= dm_ack_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_dm_d  = last_dm_q;
    cnt_d      = cnt_q;
    re_n_d     = re_n_q;
    we_n_d     = we_n_q;
    be_n_d     = be_n_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    if_ack_d   = 1'b0;
    dm_ack_d   = 1'b0;
    err_d      = 1'b0;
    finish     = 1'b0;
    // On a tie the data port wins unless it was the last one served.
    pick_dm    = dm_req_i & (~if_req_i | ~last_dm_q);

    case (state_q)
      ST_IDLE: begin
        if (if_req_i || dm_req_i) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          if (pick_dm) begin
            grant_d = PORT_DM;
            addr_d  = dm_addr_i;
            be_n_d  = dm_be_n_i;
            wdata_d = dm_wdata_i;
            re_n_d  = dm_we_i;
            we_n_d  = ~dm_we_i;
          end else begin
            grant_d = PORT_IF;
            addr_d  = if_addr_i;
            be_n_d  = BE_N_ALL;
            wdata_d = '0;
            re_n_d  = 1'b0;
            we_n_d  = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (ctl_ok_i) begin
          finish = 1'b1;
          if (!re_n_q) begin
            if (grant_q == PORT_DM) dm_rdata_d = ctl_rdata_i;
            else                    if_rdata_d = ctl_rdata_i;
          end
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TO_LIMIT) begin
            finish = 1'b1;
            err_d  = 1'b1;
          end
        end
        // Ack/err are registered on ACK entry so they line up with the
        // strobe release and the captured read data.
        if (finish) begin
          state_d  = ST_ACK;
          re_n_d   = 1'b1;
          we_n_d   = 1'b1;
          if_ack_d = (grant_q == PORT_IF);
          dm_ack_d = (grant_q == PORT_DM);
        end
      end
      ST_ACK: begin
        last_dm_d = (grant_q == PORT_DM);
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign if_ack_o    = if_ack_q;
  assign dm_ack_o    = dm_ack_q;
  assign err_o       = err_q;
  assign if_rdata_o  = if_rdata_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign ctl_re_n_o  = re_n_q;
  assign ctl_we_n_o  = we_n_q;
  assign ctl_be_n_o  = be_n_q;
  assign ctl_addr_o  = addr_q;
  assign ctl_wdata_o = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter (TIMEOUT = 8).
// Stimulus pushes expected port responses and expected controller accesses
// into queues; a port monitor and a controller model pop and compare.
module tb_mem_arbiter;

  typedef struct {
    logic        we;
    logic [3:0]  be_n;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;   // low cycles before ok; 0 = never
    int          len;     // expected low cycles; 0 = do not check
  } ctl_t;

  typedef struct {
    logic        port;    // 0 = fetch, 1 = data
    logic        err;
    logic        upd;
    logic [31:0] rdata;
  } sb_t;

  logic        clk_i, rst_n_i;
  logic        if_req_i, if_ack_o;
  logic [31:0] if_addr_i, if_rdata_o;
  logic        dm_req_i, dm_we_i, dm_ack_o;
  logic [3:0]  dm_be_n_i;
  logic [31:0] dm_addr_i, dm_wdata_i, dm_rdata_o;
  logic        err_o, ctl_re_n_o, ctl_we_n_o, ctl_ok_i;
  logic [3:0]  ctl_be_n_o;
  logic [31:0] ctl_addr_o, ctl_wdata_o, ctl_rdata_i;

  ctl_t ctl_q[$];
  sb_t  sb_q[$];
  int   n_pass = 0;
  int   n_tot = 0;
  int   ack_cnt = 0;
  bit   spur_req = 0;
  logic [31:0] exp_if_rd = '0;
  logic [31:0] exp_dm_rd = '0;

  mem_arbiter #(.TIMEOUT(8)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i),
    .if_ack_o(if_ack_o), .if_rdata_o(if_rdata_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_be_n_i(dm_be_n_i),
    .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
    .dm_ack_o(dm_ack_o), .dm_rdata_o(dm_rdata_o), .err_o(err_o),
    .ctl_re_n_o(ctl_re_n_o), .ctl_we_n_o(ctl_we_n_o),
    .ctl_be_n_o(ctl_be_n_o), .ctl_addr_o(ctl_addr_o),
    .ctl_wdata_o(ctl_wdata_o), .ctl_rdata_i(ctl_rdata_i),
    .ctl_ok_i(ctl_ok_i)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  // Port-side monitor.
  initial begin
    sb_t e;
    forever begin
      @(negedge clk_i);
      if (rst_n_i) begin
        if (!ctl_re_n_o || !ctl_we_n_o)
          chk("strobe_exclusive", 32'(ctl_re_n_o | ctl_we_n_o), 32'd1);
        if (if_ack_o || dm_ack_o) begin
          ack_cnt++;
          if (sb_q.size() == 0) begin
            chk("unexpected_ack", 32'({if_ack_o, dm_ack_o}), 32'd0);
          end else begin
            e = sb_q.pop_front();
            chk("ack_port", 32'({if_ack_o, dm_ack_o}),
                e.port ? 32'd1 : 32'd2);
            chk("err_o", 32'(err_o), 32'(e.err));
            if (e.upd) begin
              if (e.port) exp_dm_rd = e.rdata;
              else        exp_if_rd = e.rdata;
            end
            chk("if_rdata", if_rdata_o, exp_if_rd);
            chk("dm_rdata", dm_rdata_o, exp_dm_rd);
          end
        end else if (err_o) begin
          chk("err_without_ack", 32'(err_o), 32'd0);
        end
      end
    end
  end

  // Controller model: checks access fields, answers after a set delay.
  initial begin
    ctl_t cur;
    bit   in_acc = 0;
    int   len = 0;
    ctl_ok_i    = 1'b0;
    ctl_rdata_i = '0;
    cur = '{we: 0, be_n: 0, addr: 0, wdata: 0, rdata: 0, delay: 0, len: 0};
    forever begin
      @(posedge clk_i);
      #1;
      ctl_ok_i = 1'b0;
      if (!ctl_re_n_o || !ctl_we_n_o) begin
        if (!in_acc) begin
          in_acc = 1;
          len = 0;
          if (ctl_q.size() == 0) chk("unexpected_access", 32'd1, 32'd0);
          else                   cur = ctl_q.pop_front();
        end
        len++;
        chk("ctl_re_n", 32'(ctl_re_n_o), 32'(cur.we));
        chk("ctl_we_n", 32'(ctl_we_n_o), 32'(!cur.we));
        chk("ctl_be_n", 32'(ctl_be_n_o), 32'(cur.be_n));
        chk("ctl_addr", ctl_addr_o, cur.addr);
        chk("ctl_wdata", ctl_wdata_o, cur.wdata);
        if (cur.delay != 0 && len == cur.delay) begin
          ctl_ok_i    = 1'b1;
          ctl_rdata_i = cur.rdata;
        end
      end else begin
        if (in_acc) begin
          in_acc = 0;
          if (cur.len != 0) chk("strobe_low_cycles", 32'(len), 32'(cur.len));
        end
        if (spur_req) begin
          ctl_ok_i    = 1'b1;
          ctl_rdata_i = 32'hBAD0_BAD0;
          spur_req    = 0;
        end
      end
    end
  end

  task automatic wait_acks(input int target, input int budget);
    int n = 0;
    while (ack_cnt < target && n < budget) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    if (ack_cnt < target) chk("ack_timeout", 32'(ack_cnt), 32'(target));
  endtask

  task automatic access(input logic port, input logic we, input logic [3:0] be_n,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int delay,
                        input int len, input logic exp_err);
    int target = ack_cnt + 1;
    ctl_q.push_back('{we: port ? we : 1'b0, be_n: port ? be_n : 4'b0000,
                      addr: addr, wdata: port ? wdata : 32'd0,
                      rdata: rdata, delay: delay, len: len});
    sb_q.push_back('{port: port, err: exp_err,
                     upd: !(port && we) && !exp_err, rdata: rdata});
    if (port) begin
      dm_we_i = we; dm_be_n_i = be_n; dm_addr_i = addr; dm_wdata_i = wdata;
      dm_req_i = 1'b1;
    end else begin
      if_addr_i = addr;
      if_req_i  = 1'b1;
    end
    wait_acks(target, 100);
    if_req_i = 1'b0;
    dm_req_i = 1'b0;
  endtask

  initial begin
    int n;
    rst_n_i = 1'b0;
    if_req_i = 1'b0; if_addr_i = '0;
    dm_req_i = 1'b0; dm_we_i = 1'b0; dm_be_n_i = 4'hF;
    dm_addr_i = '0; dm_wdata_i = '0;
    #12;
    chk("rst_re_n", 32'(ctl_re_n_o), 32'd1);
    chk("rst_we_n", 32'(ctl_we_n_o), 32'd1);
    chk("rst_be_n", 32'(ctl_be_n_o), 32'hF);
    chk("rst_addr", ctl_addr_o, 32'd0);
    chk("rst_wdata", ctl_wdata_o, 32'd0);
    chk("rst_acks_err", 32'({if_ack_o, dm_ack_o, err_o}), 32'd0);
    chk("rst_if_rdata", if_rdata_o, 32'd0);
    chk("rst_dm_rdata", dm_rdata_o, 32'd0);
    @(negedge clk_i);
    rst_n_i = 1'b1;

    // Both ports requesting from reset: DM, IF, DM, IF.
    ctl_q.push_back('{we: 0, be_n: 4'h0, addr: 32'h2000, wdata: 32'h0,
                      rdata: 32'hA1A1_A1A1, delay: 1, len: 1});
    ctl_q.push_back('{we: 0, be_n: 4'h0, addr: 32'h0100, wdata: 32'h0,
                      rdata: 32'hB2B2_B2B2, delay: 2, len: 2});
    ctl_q.push_back('{we: 0, be_n: 4'h0, addr: 32'h2000, wdata: 32'h0,
                      rdata: 32'hA3A3_A3A3, delay: 1, len: 1});
    ctl_q.push_back('{we: 0, be_n: 4'h0, addr: 32'h0100, wdata: 32'h0,
                      rdata: 32'hB4B4_B4B4, delay: 3, len: 3});
    sb_q.push_back('{port: 1, err: 0, upd: 1, rdata: 32'hA1A1_A1A1});
    sb_q.push_back('{port: 0, err: 0, upd: 1, rdata: 32'hB2B2_B2B2});
    sb_q.push_back('{port: 1, err: 0, upd: 1, rdata: 32'hA3A3_A3A3});
    sb_q.push_back('{port: 0, err: 0, upd: 1, rdata: 32'hB4B4_B4B4});
    dm_we_i = 1'b0; dm_be_n_i = 4'h0; dm_addr_i = 32'h2000; dm_wdata_i = '0;
    if_addr_i = 32'h0100;
    @(posedge clk_i); #1;
    dm_req_i = 1'b1; if_req_i = 1'b1;
    wait_acks(4, 100);
    dm_req_i = 1'b0; if_req_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;

    // Fetch read, data write (minimum latency), data read.
    access(0, 0, 4'h0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 2, 2, 0);
    access(1, 1, 4'b1100, 32'h8000_0004, 32'h1234_5678, 32'h5A5A_5A5A, 1, 1, 0);
    access(1, 0, 4'b0011, 32'h8000_0008, 32'hFFFF_0000, 32'hCAFE_F00D, 3, 3, 0);

    // Watchdog expiry, then a normal access.
    access(0, 0, 4'h0, 32'h0000_0020, 32'h0, 32'h7777_7777, 0, 8, 1);
    access(1, 0, 4'h0, 32'h8000_000C, 32'h0, 32'h0BAD_CAFE, 2, 2, 0);

    // Spurious controller ok while idle.
    repeat (2) @(posedge clk_i);
    #1;
    spur_req = 1;
    repeat (5) @(posedge clk_i);
    #1;
    chk("spur_if_rdata", if_rdata_o, exp_if_rd);
    chk("spur_dm_rdata", dm_rdata_o, exp_dm_rd);

    // Reset during RUN: strobe released at once, access dropped.
    ctl_q.push_back('{we: 0, be_n: 4'h0, addr: 32'h0000_0040, wdata: 32'h0,
                      rdata: 32'h0, delay: 0, len: 0});
    if_addr_i = 32'h0000_0040;
    if_req_i = 1'b1;
    n = 0;
    while (ctl_re_n_o && n < 20) begin
      @(posedge clk_i); #1; n++;
    end
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("pre_rst_re_n", 32'(ctl_re_n_o), 32'd0);
    rst_n_i = 1'b0;
    #1;
    chk("midrun_rst_re_n", 32'(ctl_re_n_o), 32'd1);
    chk("midrun_rst_ack", 32'({if_ack_o, dm_ack_o}), 32'd0);
    ctl_q.push_back('{we: 0, be_n: 4'h0, addr: 32'h0000_0040, wdata: 32'h0,
                      rdata: 32'h5555_AAAA, delay: 1, len: 1});
    sb_q.push_back('{port: 0, err: 0, upd: 1, rdata: 32'h5555_AAAA});
    exp_if_rd = '0;
    exp_dm_rd = '0;
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b1;
    wait_acks(ack_cnt + 1, 100);
    if_req_i = 1'b0;

    repeat (4) @(posedge clk_i);
    #1;
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    chk("ctl_drained", 32'(ctl_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
